register_file_scoreboard: RTL and testbench
===========================================

// Module: register_file_scoreboard
// PURPOSE
//  Parametrised successor of the RV32I integer register file: NUM_READ read ports,
//  one write port, optional same-cycle write->read bypass and a per-register busy
//  scoreboard. Sits between decode (reads, reserves) and writeback (writes).
//  Lets decode detect RAW hazards on multi-cycle results without a separate hazard unit.
// PARAMETERS
//  XLEN      32  data width in bits (default equals the XLEN constant in riscv.h)
//  NREGS     32  number of architectural registers, power of two, >= 2
//  AW        5   register address width, = $clog2(NREGS)
//  NUM_READ  2   number of independent read ports, 1..4
//  BYPASS    1   1: same-cycle write data forwarded to reads; 0: reads see the array only
// PORTS
//  clock          in   1             rising-edge clock
//  reset          in   1             asynchronous, active-high
//  read_reg       in   NUM_READ*AW   read addresses; port p is bits [p*AW +: AW]
//  read_data      out  NUM_READ*XLEN read data; port p is bits [p*XLEN +: XLEN]
//  read_busy      out  NUM_READ      1 = addressed register awaits a pending write
//  write_reg      in   AW            writeback address
//  write_data     in   XLEN          writeback data
//  write_enable   in   1             commit write_data to write_reg at the clock edge
//  reserve_reg    in   AW            destination being issued by decode
//  reserve_enable in   1             mark reserve_reg busy at the clock edge
//  busy_count     out  AW+1          number of registers currently busy
// BEHAVIOUR
//  - Reset (async, any time, including mid-write): all registers = 0, all busy = 0,
//    busy_count = 0. While reset is high, read_data = 0 and read_busy = 0.
//  - Register 0 is hard zero: reads return 0, read_busy = 0, writes and reserves to 0 are ignored.
//  - Reads are combinational, zero latency. Write commits at posedge when write_enable = 1.
//  - BYPASS=1 and write_enable=1 and read_reg[p]==write_reg!=0: read_data[p]=write_data,
//    read_busy[p]=0 in the same cycle. BYPASS=0: old array value and current busy bit.
//  - Scoreboard per register r!=0, evaluated at posedge:
//      reserve_enable && reserve_reg==r            -> busy[r] <= 1 (reserve wins)
//      else write_enable && write_reg==r           -> busy[r] <= 0
//      else                                         busy[r] holds
//    Simultaneous write and reserve of the same r: data is written AND busy stays 1
//    (new producer overrides the completing one).
//  - A write to a non-busy register is legal: data updates, busy stays 0.
//  - A reserve of an already-busy register is legal: busy stays 1, no count change.
//  - busy_count is registered: updated at the same edge as busy bits, by
//    +1 (new reservation), -1 (clear) or 0 (both or neither); never exceeds NREGS-1.
//  - Multiple read ports may address the same register; each sees identical results.
// STRUCTURE
//  - XLEN stays in shared header riscv.h; add REG_ZERO (=0) and the default NREGS there.
//  - One sub-module: regfile_scoreboard (busy vector + busy_count, inputs: reserve/write
//    pairs, outputs: busy vector, count). Data array, read mux and bypass stay in the top.
//  - Read ports generated with a generate-for over NUM_READ; no per-port hand copies.
// TESTING
//  1 Reset: write x5=0xDEADBEEF, pulse reset between edges -> read x5 = 0 immediately,
//    busy_count = 0, no wait for the clock.
//  2 x0: write x0=0x1234, reserve x0 -> read x0 = 0, read_busy = 0, busy_count = 0.
//  3 Bypass: BYPASS=1, write x7=0xCAFEF00D, read port0=x7 same cycle -> 0xCAFEF00D,
//    busy 0; BYPASS=0 build -> old value 0, new value visible next cycle.
//  4 Scoreboard: reserve x3 -> next cycle read_busy(x3)=1, count=1; write x3=0x55 ->
//    next cycle busy 0, count 0, read x3 = 0x55.
//  5 Collision: x9 busy; same edge write x9=0xAA and reserve x9 -> x9=0xAA, busy 1,
//    count unchanged (1); reserve x4 + clear x9 in one edge -> count still 1.
//  6 Multi-port: NUM_READ=4, all ports read x12 after write 0x0F0F0F0F -> all four
//    return 0x0F0F0F0F; random traffic vs. reference model for 10k cycles.

Source files
------------

// File: rtl/register_file_scoreboard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard_pkg                                         |
// | Shared register-file constants and scoreboard count operation type.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package register_file_scoreboard_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } count_op_e;

endpackage
`default_nettype wire

// File: rtl/register_file_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard_if                                          |
// | Decode/writeback bus into the register file: reads, write, reserve.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface register_file_scoreboard_if
    import register_file_scoreboard_pkg::*;
#(
    parameter int XLEN     = register_file_scoreboard_pkg::XLEN,
    parameter int AW       = 5,
    parameter int NUM_READ = 2
);
    logic [NUM_READ*AW-1:0]   read_reg;
    logic [NUM_READ*XLEN-1:0] read_data;
    logic [NUM_READ-1:0]      read_busy;
    logic [AW-1:0]            write_reg;
    logic [XLEN-1:0]          write_data;
    logic                     write_enable;
    logic [AW-1:0]            reserve_reg;
    logic                     reserve_enable;
    logic [AW:0]              busy_count;

    modport master (
        output read_reg, write_reg, write_data, write_enable, reserve_reg, reserve_enable,
        input  read_data, read_busy, busy_count
    );

    modport slave (
        input  read_reg, write_reg, write_data, write_enable, reserve_reg, reserve_enable,
        output read_data, read_busy, busy_count
    );
endinterface
`default_nettype wire

// File: rtl/register_file_scoreboard_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard                                                   |
// | Per-register busy bits plus a registered count of busy registers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int NREGS = register_file_scoreboard_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [AW-1:0]    reserve_reg_i,
    input  wire logic             reserve_enable_i,
    input  wire logic [AW-1:0]    write_reg_i,
    input  wire logic             write_enable_i,
    output logic      [NREGS-1:0] busy_o,
    output logic      [AW:0]      count_o
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             set, clr, inc, dec;
    count_op_e        op;

    always_comb begin
        set = reserve_enable_i && (reserve_reg_i != AW'(REG_ZERO));
        // A reservation on the register being written keeps it busy: newer producer wins.
        clr = write_enable_i && (write_reg_i != AW'(REG_ZERO))
              && !(set && (reserve_reg_i == write_reg_i));
        busy_d = busy_q;
        if (clr) busy_d[write_reg_i] = 1'b0;
        if (set) busy_d[reserve_reg_i] = 1'b1;
        inc = set && !busy_q[reserve_reg_i];
        dec = clr && busy_q[write_reg_i];
        if (inc && !dec)      op = CNT_INC;
        else if (dec && !inc) op = CNT_DEC;
        else                  op = CNT_HOLD;
        case (op)
            CNT_INC: count_d = count_q + (AW+1)'(1);
            CNT_DEC: count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_scoreboard                                             |
// | Multi-port integer register file with bypass and busy scoreboard.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int XLEN     = register_file_scoreboard_pkg::XLEN,
    parameter int NREGS    = register_file_scoreboard_pkg::NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1
) (
    input wire logic                  clock,
    input wire logic                  reset,
    register_file_scoreboard_if.slave bus
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (bus.write_enable && (bus.write_reg != AW'(REG_ZERO))) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clock            (clock),
        .reset            (reset),
        .reserve_reg_i    (bus.reserve_reg),
        .reserve_enable_i (bus.reserve_enable),
        .write_reg_i      (bus.write_reg),
        .write_enable_i   (bus.write_enable),
        .busy_o           (busy),
        .count_o          (bus.busy_count)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [AW-1:0] addr;
        logic          hit;
        logic          quiet;

        assign addr  = bus.read_reg[p*AW +: AW];
        assign hit   = (BYPASS != 0) && bus.write_enable && (bus.write_reg == addr);
        // x0 and an active reset both force a clean zero, independent of array contents.
        assign quiet = reset || (addr == AW'(REG_ZERO));

        assign bus.read_data[p*XLEN +: XLEN] = quiet ? '0 :
                                               hit   ? bus.write_data : regs_q[addr];
        assign bus.read_busy[p]              = !quiet && !hit && busy[addr];
    end
endmodule
`default_nettype wire

// File: tb/tb_register_file_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_register_file_scoreboard                                          |
// | Directed and model-compared checks on bypass and non-bypass builds.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_register_file_scoreboard;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    register_file_scoreboard_if #(.XLEN(32), .AW(5), .NUM_READ(4)) if4 ();
    register_file_scoreboard_if #(.XLEN(32), .AW(5), .NUM_READ(2)) if0 ();

    register_file_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NUM_READ(4), .BYPASS(1)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (if4.slave)
    );

    register_file_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NUM_READ(2), .BYPASS(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic re, input logic [4:0] rr);
        if4.write_enable = we;  if4.write_reg = wr;  if4.write_data = wd;
        if4.reserve_enable = re; if4.reserve_reg = rr;
        if0.write_enable = we;  if0.write_reg = wr;  if0.write_data = wd;
        if0.reserve_enable = re; if0.reserve_reg = rr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
        if4.read_reg = {a3, a2, a1, a0};
        if0.read_reg = {a1, a0};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        set_reads(5'd5, 5'd6, 5'd5, 5'd5);
        #1;
        tests++; if (if4.read_data !== 128'h0) begin fails++; $display("FAIL reset_data: got %h want 0", if4.read_data); end
        tests++; if (if4.busy_count !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", if4.busy_count); end
        @(negedge clock);
        reset = 1'b0;
        step();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);
        step();
        idle();
        #1;
        tests++; if (if4.read_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL pre_reset_x5: got %h want deadbeef", if4.read_data[31:0]); end
        tests++; if (if4.busy_count !== 6'd1) begin fails++; $display("FAIL pre_reset_count: got %0d want 1", if4.busy_count); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (if4.read_data[31:0] !== 32'h0) begin fails++; $display("FAIL async_reset_x5: got %h want 0", if4.read_data[31:0]); end
        tests++; if (if4.busy_count !== 6'd0) begin fails++; $display("FAIL async_reset_count: got %0d want 0", if4.busy_count); end
        tests++; if (if4.read_busy[1] !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b want 0", if4.read_busy[1]); end
        #1;
        reset = 1'b0;
        step();
        tests++; if (if4.read_data[31:0] !== 32'h0) begin fails++; $display("FAIL post_reset_x5: got %h want 0", if4.read_data[31:0]); end
    endtask

    task automatic test_x0();
        set_reads(5'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
        #1;
        tests++; if (if4.read_data[31:0] !== 32'h0) begin fails++; $display("FAIL x0_bypass: got %h want 0", if4.read_data[31:0]); end
        step();
        idle();
        #1;
        tests++; if (if4.read_data[31:0] !== 32'h0) begin fails++; $display("FAIL x0_data: got %h want 0", if4.read_data[31:0]); end
        tests++; if (if4.read_busy[0] !== 1'b0) begin fails++; $display("FAIL x0_busy: got %b want 0", if4.read_busy[0]); end
        tests++; if (if4.busy_count !== 6'd0) begin fails++; $display("FAIL x0_count: got %0d want 0", if4.busy_count); end
    endtask

    task automatic test_bypass();
        set_reads(5'd7, 5'd7, 5'd7, 5'd7);
        drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0);
        #1;
        tests++; if (if4.read_data[31:0] !== 32'hCAFEF00D) begin fails++; $display("FAIL bypass_on: got %h want cafef00d", if4.read_data[31:0]); end
        tests++; if (if4.read_busy[0] !== 1'b0) begin fails++; $display("FAIL bypass_on_busy: got %b want 0", if4.read_busy[0]); end
        tests++; if (if0.read_data[31:0] !== 32'h0) begin fails++; $display("FAIL bypass_off: got %h want 0", if0.read_data[31:0]); end
        step();
        idle();
        #1;
        tests++; if (if0.read_data[31:0] !== 32'hCAFEF00D) begin fails++; $display("FAIL bypass_off_next: got %h want cafef00d", if0.read_data[31:0]); end
    endtask

    task automatic test_scoreboard();
        set_reads(5'd3, 5'd3, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        step();
        idle();
        #1;
        tests++; if (if4.read_busy[0] !== 1'b1) begin fails++; $display("FAIL sb_busy: got %b want 1", if4.read_busy[0]); end
        tests++; if (if4.busy_count !== 6'd1) begin fails++; $display("FAIL sb_count: got %0d want 1", if4.busy_count); end
        tests++; if (if0.read_busy[1] !== 1'b1) begin fails++; $display("FAIL sb_busy_nobyp: got %b want 1", if0.read_busy[1]); end
        drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
        #1;
        tests++; if (if4.read_busy[0] !== 1'b0) begin fails++; $display("FAIL sb_bypass_busy: got %b want 0", if4.read_busy[0]); end
        tests++; if (if0.read_busy[0] !== 1'b1) begin fails++; $display("FAIL sb_nobyp_busy: got %b want 1", if0.read_busy[0]); end
        step();
        idle();
        #1;
        tests++; if (if4.read_busy[0] !== 1'b0) begin fails++; $display("FAIL sb_clear_busy: got %b want 0", if4.read_busy[0]); end
        tests++; if (if4.busy_count !== 6'd0) begin fails++; $display("FAIL sb_clear_count: got %0d want 0", if4.busy_count); end
        tests++; if (if0.read_data[31:0] !== 32'h55) begin fails++; $display("FAIL sb_data: got %h want 55", if0.read_data[31:0]); end
    endtask

    task automatic test_collision();
        set_reads(5'd9, 5'd4, 5'd9, 5'd4);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        step();
        drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9);
        step();
        idle();
        #1;
        tests++; if (if4.read_data[31:0] !== 32'hAA) begin fails++; $display("FAIL coll_data: got %h want aa", if4.read_data[31:0]); end
        tests++; if (if4.read_busy[0] !== 1'b1) begin fails++; $display("FAIL coll_busy: got %b want 1", if4.read_busy[0]); end
        tests++; if (if4.busy_count !== 6'd1) begin fails++; $display("FAIL coll_count: got %0d want 1", if4.busy_count); end
        drive(1'b1, 5'd9, 32'hBB, 1'b1, 5'd4);
        step();
        idle();
        #1;
        tests++; if (if4.busy_count !== 6'd1) begin fails++; $display("FAIL swap_count: got %0d want 1", if4.busy_count); end
        tests++; if (if4.read_busy[1:0] !== 2'b10) begin fails++; $display("FAIL swap_busy: got %b want 10", if4.read_busy[1:0]); end
        tests++; if (if4.read_data[31:0] !== 32'hBB) begin fails++; $display("FAIL swap_data: got %h want bb", if4.read_data[31:0]); end
        drive(1'b1, 5'd4, 32'h0, 1'b0, 5'd0);
        step();
        idle();
        #1;
        tests++; if (if4.busy_count !== 6'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", if4.busy_count); end
    endtask

    task automatic test_multiport();
        set_reads(5'd12, 5'd12, 5'd12, 5'd12);
        drive(1'b1, 5'd12, 32'h0F0F0F0F, 1'b0, 5'd0);
        step();
        idle();
        #1;
        for (int p = 0; p < 4; p++) begin
            tests++;
            if (if4.read_data[p*32 +: 32] !== 32'h0F0F0F0F) begin
                fails++; $display("FAIL multiport_p%0d: got %h want 0f0f0f0f", p, if4.read_data[p*32 +: 32]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] m_regs [32];
        logic        m_busy [32];
        int          m_count;
        logic        we, re;
        logic [4:0]  wr, rr;
        logic [31:0] wd;
        logic [4:0]  a [4];
        logic [31:0] exp_d;
        logic        exp_b;

        @(negedge clock);
        reset = 1'b1;
        idle();
        #1;
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin m_regs[r] = 32'h0; m_busy[r] = 1'b0; end
        step();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(0, 31));
            rr = 5'($urandom_range(0, 31));
            wd = $urandom;
            for (int p = 0; p < 4; p++)
                a[p] = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            drive(we, wr, wd, re, rr);
            set_reads(a[0], a[1], a[2], a[3]);
            #1;
            m_count = 0;
            for (int r = 0; r < 32; r++) if (m_busy[r]) m_count++;
            tests++;
            if (int'(if4.busy_count) != m_count) begin
                fails++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, if4.busy_count, m_count);
            end
            for (int p = 0; p < 4; p++) begin
                if (a[p] == 5'd0)               begin exp_d = 32'h0; exp_b = 1'b0; end
                else if (we && wr == a[p])      begin exp_d = wd;    exp_b = 1'b0; end
                else                            begin exp_d = m_regs[a[p]]; exp_b = m_busy[a[p]]; end
                tests++;
                if (if4.read_data[p*32 +: 32] !== exp_d || if4.read_busy[p] !== exp_b) begin
                    fails++; $display("FAIL rnd_byp cyc %0d p%0d: got %h/%b want %h/%b", cyc, p,
                                      if4.read_data[p*32 +: 32], if4.read_busy[p], exp_d, exp_b);
                end
            end
            for (int p = 0; p < 2; p++) begin
                exp_d = (a[p] == 5'd0) ? 32'h0 : m_regs[a[p]];
                exp_b = (a[p] == 5'd0) ? 1'b0  : m_busy[a[p]];
                tests++;
                if (if0.read_data[p*32 +: 32] !== exp_d || if0.read_busy[p] !== exp_b) begin
                    fails++; $display("FAIL rnd_nobyp cyc %0d p%0d: got %h/%b want %h/%b", cyc, p,
                                      if0.read_data[p*32 +: 32], if0.read_busy[p], exp_d, exp_b);
                end
            end
            if (we && wr != 5'd0) begin m_regs[wr] = wd; m_busy[wr] = 1'b0; end
            if (re && rr != 5'd0) m_busy[rr] = 1'b1;
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        set_reads(5'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_multiport();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
